// File: rtl/register.sv
// Shared pipeline-register primitive: WIDTH-bit flop bank with load enable
// and synchronous active-low reset to RST_VAL. One clock of latency, no output logic.
module register #(
  parameter int WIDTH   = 32,
  parameter     RST_VAL = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] o_q,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_rst_n,
  input  logic             i_clk
);

  // RST_VAL may arrive as an unsized or wider literal; only set bits above WIDTH are an error.
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("register: WIDTH=%0d outside 1..1024", WIDTH);
  end
  if ($bits(RST_VAL) > WIDTH) begin : g_wide_rst
    if (|(RST_VAL >> WIDTH)) begin : g_bad_rst
      $error("register: RST_VAL does not fit in WIDTH=%0d bits", WIDTH);
    end
  end

  localparam logic [WIDTH-1:0] L_RST_VAL = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= L_RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for register: stimulus pushes expected post-edge values,
// a negedge monitor pops and compares against each instance.
module tb_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=32 default instance
  logic        rst32_n, en32;
  logic [31:0] d32, q32;
  // WIDTH=8 with non-zero reset value
  logic        rst8_n, en8;
  logic [7:0]  d8, q8;
  // WIDTH=1 via positional parameter, WIDTH=5 via defparam
  logic        rstr_n, en1, en5;
  logic [0:0]  d1, q1;
  logic [4:0]  d5, q5;

  register u_w32 (.o_q(q32), .i_en(en32), .i_d(d32), .i_rst_n(rst32_n), .i_clk(clk));
  register #(.WIDTH(8), .RST_VAL(8'h3C)) u_w8 (.o_q(q8), .i_en(en8), .i_d(d8), .i_rst_n(rst8_n), .i_clk(clk));
  register #(1) u_w1 (.o_q(q1), .i_en(en1), .i_d(d1), .i_rst_n(rstr_n), .i_clk(clk));
  register u_w5 (.o_q(q5), .i_en(en5), .i_d(d5), .i_rst_n(rstr_n), .i_clk(clk));
  defparam u_w5.WIDTH = 5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb32[$];
  logic [7:0]  sb8[$];
  logic [0:0]  sb1[$];
  logic [4:0]  sb5[$];

  // Reference state for the randomly driven narrow instances
  logic [0:0] m1;
  logic [4:0] m5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge; e32/e8 are the hand-computed values o_q must show after it.
  task automatic tick(input logic [31:0] e32, input logic [7:0] e8);
    logic [0:0] n1;
    logic [4:0] n5;
    n1 = !rstr_n ? 1'b0 : (en1 ? d1 : m1);
    n5 = !rstr_n ? 5'd0 : (en5 ? d5 : m5);
    @(posedge clk);
    m1 = n1;
    m5 = n5;
    sb32.push_back(e32);
    sb8.push_back(e8);
    sb1.push_back(n1);
    sb5.push_back(n5);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb32.size() > 0) check("q32", q32, sb32.pop_front());
    if (sb8.size() > 0)  check("q8", {24'd0, q8}, {24'd0, sb8.pop_front()});
    if (sb1.size() > 0)  check("q1", {31'd0, q1}, {31'd0, sb1.pop_front()});
    if (sb5.size() > 0)  check("q5", {27'd0, q5}, {27'd0, sb5.pop_front()});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m1 = '0; m5 = '0;
    rst32_n = 1'b0; en32 = 1'b1; d32 = 32'hDEADBEEF;
    rst8_n  = 1'b0; en8  = 1'b1; d8  = 8'hFF;
    rstr_n  = 1'b0; en1  = 1'b1; d1  = 1'b1; en5 = 1'b1; d5 = 5'h1F;
    #1;
    // Reset held for two edges despite enable and data
    tick(32'h0, 8'h3C);
    tick(32'h0, 8'h3C);

    rst32_n = 1'b1; rst8_n = 1'b1; rstr_n = 1'b1;
    en32 = 1'b1; d32 = 32'h12345678;
    en8 = 1'b1; d8 = 8'h55;
    en1 = 1'b0; en5 = 1'b0;
    #2 check("q32_before_load", q32, 32'h0);
    tick(32'h12345678, 8'h55);

    // Hold for three edges while data toggles
    en32 = 1'b0; d32 = 32'hFFFFFFFF;
    en8 = 1'b0; d8 = 8'hAA;
    tick(32'h12345678, 8'h55);
    tick(32'h12345678, 8'h55);
    tick(32'h12345678, 8'h55);

    en32 = 1'b1; d32 = 32'hA5A5A5A5;
    tick(32'hA5A5A5A5, 8'h55);

    // Reset glitch between edges must not disturb the flops
    en32 = 1'b0;
    rst32_n = 1'b0; rst8_n = 1'b0;
    #2;
    rst32_n = 1'b1; rst8_n = 1'b1;
    #1 check("q32_rst_glitch", q32, 32'hA5A5A5A5);
    check("q8_rst_glitch", {24'd0, q8}, 32'h55);
    tick(32'hA5A5A5A5, 8'h55);

    // Reset at an edge wins over enable
    rst32_n = 1'b0; en32 = 1'b1; d32 = 32'h0BADF00D;
    rst8_n = 1'b0; en8 = 1'b1; d8 = 8'h99;
    tick(32'h0, 8'h3C);

    // After release, value stays at reset until enabled
    rst32_n = 1'b1; en32 = 1'b0; rst8_n = 1'b1; en8 = 1'b0;
    tick(32'h0, 8'h3C);
    tick(32'h0, 8'h3C);
    en32 = 1'b1; d32 = 32'h00000001; en8 = 1'b1; d8 = 8'h00;
    tick(32'h00000001, 8'h00);
    en32 = 1'b0; en8 = 1'b0;

    // Random enable/data on the narrow instances, occasional reset
    for (int i = 0; i < 1000; i++) begin
      rstr_n = ($urandom_range(0, 49) != 0);
      en1 = $urandom_range(0, 1);
      d1  = 1'($urandom_range(0, 1));
      en5 = $urandom_range(0, 1);
      d5  = 5'($urandom_range(0, 31));
      tick(32'h00000001, 8'h00);
    end

    @(negedge clk);
    #1;
    check("sb_drained", sb32.size() + sb8.size() + sb1.size() + sb5.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
